// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared width, state encoding and mask helper for rand_range_reducer
package rand_pkg;

  localparam int RAND_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    REJ  = 2'd2,
    DONE = 2'd3
  } rand_state_t;

  // Smallest all-ones mask covering n-1, so that (word & mask) spans at least [0, n-1].
  function automatic logic [RAND_WIDTH-1:0] ceil_pow2_mask(input logic [RAND_WIDTH-1:0] n);
    logic [RAND_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < RAND_WIDTH; i++) begin
      if (m < (n - RAND_WIDTH'(1))) m = {m[RAND_WIDTH-2:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_range_reducer_mod_step.sv
// rtl/rand_range_reducer_mod_step.sv - one restoring-modulo iteration (shift, compare, subtract)
module mod_step #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem
);

  // The shifted remainder needs WIDTH+1 bits: with a divisor >= 2^(WIDTH-1) the
  // previous remainder may already have its MSB set before the shift.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // Restore when the shifted value is below the divisor; either result fits in WIDTH bits.
  always_comb begin
    o_rem = w_shift[WIDTH-1:0];
    if (w_shift >= {1'b0, i_divisor}) o_rem = w_diff[WIDTH-1:0];
  end

endmodule

// File: rtl/rand_range_reducer.sv
// rtl/rand_range_reducer.sv - request/response reducer of the LFSR word into [0, N-1]; optional RAND_UNBIASED_EN rejection sampling
module rand_range_reducer
  import rand_pkg::*;
#(
  parameter int WIDTH     = RAND_WIDTH,
  parameter int MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rand_in,
  input  logic [WIDTH-1:0] range_in,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_err
);

  localparam int CW = $clog2(WIDTH);

  rand_state_t      r_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_value;
  logic             r_rsp_err;
  logic [WIDTH-1:0] w_rem_next;

`ifdef RAND_UNBIASED_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [WIDTH-1:0] r_mask;
  logic [RW-1:0]    r_retry;
  logic [WIDTH-1:0] w_sample;

  // Fresh LFSR word every rejection cycle, narrowed to the smallest covering power of two.
  assign w_sample = rand_in & r_mask;
`else
  logic w_unused_retry;
  assign w_unused_retry = (MAX_RETRY != 0);
`endif

  mod_step #(.WIDTH(WIDTH)) u_mod_step (
    .i_rem     (r_rem),
    .i_bit     (r_dividend[r_cnt]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_value = r_rsp_value;
  assign rsp_err   = r_rsp_err;

  // Control FSM: accept one request, reduce it, hold the result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_value <= '0;
      r_rsp_err   <= 1'b0;
`ifdef RAND_UNBIASED_EN
      r_mask      <= '0;
      r_retry     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_dividend  <= rand_in;
            r_divisor   <= range_in;
            r_rem       <= '0;
            r_cnt       <= CW'(WIDTH - 1);
            r_req_ready <= 1'b0;
            if (range_in == '0) begin
              r_rsp_err <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_rsp_err <= 1'b0;
`ifdef RAND_UNBIASED_EN
              r_mask    <= ceil_pow2_mask(range_in);
              r_retry   <= '0;
              r_state   <= REJ;
`else
              r_state   <= DIV;
`endif
            end
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          if (r_cnt == '0) r_state <= DONE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
`ifdef RAND_UNBIASED_EN
        REJ: begin
          if (w_sample < r_divisor) begin
            r_rem   <= w_sample;
            r_state <= DONE;
          end else if (r_retry == RW'(MAX_RETRY - 1)) begin
            // Out of retries: fall back to modulo of the word seen this cycle.
            r_dividend <= rand_in;
            r_rem      <= '0;
            r_cnt      <= CW'(WIDTH - 1);
            r_state    <= DIV;
          end else begin
            r_retry <= r_retry + RW'(1);
          end
        end
`endif
        DONE: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_value <= r_rem;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_range_reducer.sv
// tb/tb_rand_range_reducer.sv - directed table-driven bench for rand_range_reducer
module tb_rand_range_reducer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] rand_in;
  logic [12:0] range_in;
  logic        req_valid;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [12:0] rsp_value;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rand_range_reducer #(.WIDTH(13), .MAX_RETRY(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rand_in   (rand_in),
    .range_in  (range_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_value (rsp_value),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [12:0] r;
    logic [12:0] n;
    logic [12:0] v;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected value: hand-computed modulo result, or the rejection-sampling rule when enabled.
  function automatic logic [12:0] exp_of(input logic [12:0] r, input logic [12:0] n,
                                         input logic [12:0] hand);
`ifdef RAND_UNBIASED_EN
    logic [12:0] m;
    logic [12:0] s;
    if (n == 0) return 13'd0;
    m = 0;
    while ({19'd0, m} < ({19'd0, n} - 32'd1)) m = 13'((32'(m) * 2) + 1);
    s = r & m;
    if (s < n) return s;
    return r % n;
`else
    if (r == 13'h1FFF && n == 13'd0) return 13'd1;
    return hand;
`endif
  endfunction

  task automatic send_and_wait(input logic [12:0] r, input logic [12:0] n, output int lat);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
    rand_in   = r;
    range_in  = n;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifndef RAND_UNBIASED_EN
    rand_in  = 13'($urandom);
    range_in = 13'($urandom);
`endif
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    check("rsp_valid_within_bound", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake(input logic [12:0] last_val);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
    check("rsp_value_retained", {19'd0, rsp_value}, {19'd0, last_val});
  endtask

  initial begin
    int lat;
    logic seen;
    logic [12:0] ev;

    vecs[0]  = '{13'h000F, 13'd6,    13'd3,    1'b0, 14};
    vecs[1]  = '{13'h1FFF, 13'd10,   13'd1,    1'b0, 14};
    vecs[2]  = '{13'h1FFF, 13'h1FFF, 13'd0,    1'b0, 14};
    vecs[3]  = '{13'h1FFF, 13'd1,    13'd0,    1'b0, 14};
    vecs[4]  = '{13'h0123, 13'd0,    13'd0,    1'b1, 1};
    vecs[5]  = '{13'd100,  13'd7,    13'd2,    1'b0, 14};
    vecs[6]  = '{13'd5,    13'd100,  13'd5,    1'b0, 14};
    vecs[7]  = '{13'h1234, 13'h1000, 13'd564,  1'b0, 14};
    vecs[8]  = '{13'h1FFE, 13'h1001, 13'd4093, 1'b0, 14};
    vecs[9]  = '{13'd1000, 13'd37,   13'd1,    1'b0, 14};
    vecs[10] = '{13'h0ABC, 13'd255,  13'd198,  1'b0, 14};

    rst_n     = 1'b0;
    rand_in   = '0;
    range_in  = '0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_value", {19'd0, rsp_value}, 32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      send_and_wait(vecs[i].r, vecs[i].n, lat);
      ev = vecs[i].e ? 13'd0 : exp_of(vecs[i].r, vecs[i].n, vecs[i].v);
      check($sformatf("vec%0d_value", i), {19'd0, rsp_value}, {19'd0, ev});
      check($sformatf("vec%0d_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].e});
      check($sformatf("vec%0d_req_ready_busy", i), {31'd0, req_ready}, 32'd0);
`ifdef RAND_UNBIASED_EN
      if (vecs[i].e) check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
`else
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
`endif
      handshake(ev);
    end

    // Backpressure: result held 20 cycles while a pending request waits.
    send_and_wait(13'd47, 13'd7, lat);
    @(negedge clk);
    rand_in   = 13'd100;
    range_in  = 13'd7;
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_value", {19'd0, rsp_value}, 32'd5);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("hs_rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("hs_req_not_taken",  {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("next_idle_accept", {31'd0, req_ready}, 32'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    check("pending_req_valid", {31'd0, rsp_valid}, 32'd1);
    ev = exp_of(13'd100, 13'd7, 13'd2);
    check("pending_req_value", {19'd0, rsp_value}, {19'd0, ev});
    handshake(ev);

    // Reset in the 6th DIV cycle drops the request.
    @(negedge clk);
    rand_in   = 13'd47;
    range_in  = 13'd7;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_rsp_value", {19'd0, rsp_value}, 32'd0);
    check("midrst_rsp_err",   {31'd0, rsp_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", {31'd0, seen}, 32'd0);
    send_and_wait(13'd100, 13'd7, lat);
    ev = exp_of(13'd100, 13'd7, 13'd2);
    check("post_reset_value", {19'd0, rsp_value}, {19'd0, ev});
    handshake(ev);

`ifdef RAND_UNBIASED_EN
    // Two rejections then an accept: 7, 6, 3 with N=5.
    @(negedge clk);
    rand_in   = 13'd0;
    range_in  = 13'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rand_in   = 13'd7;
    @(posedge clk);
    #1;
    rand_in = 13'd6;
    @(posedge clk);
    #1;
    rand_in = 13'h0003;
    lat = 2;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    check("rej_value", {19'd0, rsp_value}, 32'd3);
    check("rej_latency", lat, 4);
    handshake(13'd3);

    // All four samples rejected: modulo of the 4th sample, 8189 mod 5 = 4.
    @(negedge clk);
    rand_in   = 13'd7;
    range_in  = 13'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rand_in = 13'h1FFD;
    lat = 3;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      rand_in = 13'd7;
      if (rsp_valid) break;
    end
    check("fallback_value", {19'd0, rsp_value}, 32'd4);
    check("fallback_latency", lat, 18);
    handshake(13'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
